// File: rtl/cplx_vec_norm.sv
// cplx_vec_norm
// Streaming column-norm unit. It accepts N complex samples, accumulates
// sum(re^2 + im^2) and computes the integer square root of that energy with a
// restoring bit-serial iterator that produces one root bit per cycle. The norm
// and the raw energy are then held on a valid/ready output until they are
// accepted.
//
// Optional build macro:
//   CPLX_VEC_NORM_ROUND_EN - o_norm is round-to-nearest of sqrt(energy) and
//                            saturates at 2^R-1. When the macro is undefined,
//                            o_norm is floor(sqrt(energy)).
//
// Ports:
//   i_clk     clock
//   i_rst     asynchronous active-high reset
//   i_vld     input sample valid
//   i_re      signed real part, W bits
//   i_im      signed imaginary part, W bits
//   o_rdy     sample accepted this cycle when i_vld is also high
//   o_vld     result valid, held until i_rdy
//   i_rdy     downstream accepts the result
//   o_norm    unsigned norm, R bits
//   o_energy  unsigned accumulated energy, ACC_W bits
module cplx_vec_norm #(
    parameter  int W     = 16,
    parameter  int N     = 4,
    localparam int ACC_W = 2 * W + $clog2(N),
    localparam int R     = (ACC_W + 1) / 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_vld,
    input  logic signed [W-1:0] i_re,
    input  logic signed [W-1:0] i_im,
    output logic                o_rdy,
    output logic                o_vld,
    input  logic                i_rdy,
    output logic [R-1:0]        o_norm,
    output logic [ACC_W-1:0]    o_energy
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IT_W  = (R > 1) ? $clog2(R) : 1;
    localparam int OP_W  = 2 * R;
    localparam int REM_W = R + 2;
    // The shifted remainder is compared before the subtraction, so it carries
    // two extra bits above the stored remainder.
    localparam int SH_W  = REM_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_SQRT,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ACC_W-1:0]     acc_q;
    logic [ACC_W-1:0]     acc_d;
    logic [OP_W-1:0]      op_q;
    logic [REM_W-1:0]     rem_q;
    logic [REM_W-1:0]     rem_d;
    logic [R-1:0]         root_q;
    logic [R-1:0]         root_d;
    logic [R-1:0]         norm_d;
    logic [IT_W-1:0]      it_q;
    logic                 vld_q;
    logic [R-1:0]         norm_q;
    logic [ACC_W-1:0]     energy_q;

    logic signed [2*W-1:0] sq_re;
    logic signed [2*W-1:0] sq_im;
    logic [ACC_W-1:0]      energy_s;
    logic                  accept;
    logic                  last;
    logic [SH_W-1:0]       rem_sh;
    logic [SH_W-1:0]       trial;
    logic                  take;

`ifdef CPLX_VEC_NORM_ROUND_EN
    // The final remainder equals acc - root^2. Rounding up is correct when
    // that remainder exceeds root, because (root+0.5)^2 = root^2 + root + 0.25.
    function automatic logic [R-1:0] round_norm(input logic [R-1:0]     root,
                                                input logic [REM_W-1:0] rem);
        logic [R-1:0] res;
        res = root;
        if ((rem > REM_W'(root)) && (root != {R{1'b1}})) begin
            res = root + R'(1);
        end
        return res;
    endfunction
`endif

    // Accepting samples is decoded from the state alone.
    assign o_rdy  = (state_q == S_IDLE) || (state_q == S_ACC);
    assign accept = i_vld & o_rdy;

    always_comb begin
        // Both squares are non-negative and at most 2^(2W-2), so their
        // unsigned reinterpretation is exact.
        sq_re    = i_re * i_re;
        sq_im    = i_im * i_im;
        energy_s = ACC_W'($unsigned(sq_re)) + ACC_W'($unsigned(sq_im));
        // The first sample of a vector replaces the old energy.
        acc_d    = (state_q == S_IDLE) ? energy_s : acc_q + energy_s;
        last     = (cnt_q == CNT_W'(N - 1));

        // Restoring square-root step: bring down the next two operand bits,
        // then try subtracting (4*root + 1).
        rem_sh   = {rem_q, op_q[OP_W-1 -: 2]};
        trial    = SH_W'({root_q, 2'b01});
        take     = (rem_sh >= trial);
        rem_d    = REM_W'(take ? (rem_sh - trial) : rem_sh);
        root_d   = {root_q[R-2:0], take};
`ifdef CPLX_VEC_NORM_ROUND_EN
        norm_d   = round_norm(root_d, rem_d);
`else
        norm_d   = root_d;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            it_q     <= '0;
            vld_q    <= 1'b0;
            norm_q   <= '0;
            energy_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_ACC: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        if (last) begin
                            // N = 1 leaves IDLE directly for SQRT.
                            state_q <= S_SQRT;
                            cnt_q   <= '0;
                            op_q    <= OP_W'(acc_d);
                            rem_q   <= '0;
                            root_q  <= '0;
                            it_q    <= '0;
                        end else begin
                            state_q <= S_ACC;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_SQRT: begin
                    op_q   <= op_q << 2;
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    it_q   <= it_q + IT_W'(1);
                    if (it_q == IT_W'(R - 1)) begin
                        state_q  <= S_DONE;
                        vld_q    <= 1'b1;
                        norm_q   <= norm_d;
                        energy_q <= acc_q;
                    end
                end
                S_DONE: begin
                    if (i_rdy) begin
                        state_q <= S_IDLE;
                        vld_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    vld_q   <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_vld    = vld_q;
    assign o_norm   = norm_q;
    assign o_energy = energy_q;

endmodule

// File: tb/tb_cplx_vec_norm.sv
// Self-checking bench for cplx_vec_norm with the default W=16, N=4 configuration.
// Expected results come from a reference model and are pushed to a scoreboard
// when a vector is driven. They are popped when the unit presents o_vld.
module tb_cplx_vec_norm;

    localparam int W     = 16;
    localparam int N     = 4;
    localparam int ACC_W = 2 * W + $clog2(N);
    localparam int R     = (ACC_W + 1) / 2;

    logic                i_clk;
    logic                i_rst;
    logic                i_vld;
    logic signed [W-1:0] i_re;
    logic signed [W-1:0] i_im;
    logic                o_rdy;
    logic                o_vld;
    logic                i_rdy;
    logic [R-1:0]        o_norm;
    logic [ACC_W-1:0]    o_energy;

    cplx_vec_norm #(.W(W), .N(N)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_vld    (i_vld),
        .i_re     (i_re),
        .i_im     (i_im),
        .o_rdy    (o_rdy),
        .o_vld    (o_vld),
        .i_rdy    (i_rdy),
        .o_norm   (o_norm),
        .o_energy (o_energy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        longint energy;
        longint norm;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact energy, binary-search integer square root, optional rounding.
    function automatic exp_t model(input int re[4], input int im[4]);
        exp_t   m;
        longint e;
        longint lo;
        longint hi;
        longint mid;
        longint top;
        e = 0;
        for (int i = 0; i < N; i++) begin
            e += longint'(re[i]) * longint'(re[i]) + longint'(im[i]) * longint'(im[i]);
        end
        top = (longint'(1) << R) - 1;
        lo  = 0;
        hi  = top;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= e) lo = mid;
            else hi = mid - 1;
        end
`ifdef CPLX_VEC_NORM_ROUND_EN
        if ((e - lo * lo > lo) && (lo < top)) lo = lo + 1;
`endif
        m.energy = e;
        m.norm   = lo;
        return m;
    endfunction

    task automatic send_vec(input int re[4], input int im[4], input bit gap, output int last_c);
        sb.push_back(model(re, im));
        last_c = 0;
        for (int i = 0; i < N; i++) begin
            @(negedge i_clk);
            chk("rdy_at_sample", 64'(o_rdy), 64'd1);
            i_vld  = 1'b1;
            i_re   = W'(re[i]);
            i_im   = W'(im[i]);
            last_c = cyc;
            if (gap) begin
                @(negedge i_clk);
                i_vld = 1'b0;
            end
        end
        @(negedge i_clk);
        i_vld = 1'b0;
    endtask

    task automatic get_result(input string tag, input int last_c, input bit chk_lat, output exp_t e);
        int n;
        n        = 0;
        e.energy = -1;
        e.norm   = -1;
        while (o_vld !== 1'b1 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk({tag, "_vld"}, 64'(o_vld), 64'd1);
        if (o_vld === 1'b1) begin
            chk({tag, "_sb"}, 64'(sb.size()), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_energy"}, 64'(o_energy), 64'(e.energy));
                chk({tag, "_norm"}, 64'(o_norm), 64'(e.norm));
            end
            if (chk_lat) chk({tag, "_latency"}, 64'(cyc - last_c), 64'(R + 1));
        end
    endtask

    // With i_rdy already high, DONE must last exactly one cycle.
    task automatic release_check(input string tag);
        @(negedge i_clk);
        chk({tag, "_vld_drop"}, 64'(o_vld), 64'd0);
        chk({tag, "_rdy_back"}, 64'(o_rdy), 64'd1);
    endtask

    initial begin
        int   ra[4];
        int   ia[4];
        int   lc;
        int   spurious;
        exp_t e;

        i_rst = 1'b1;
        i_vld = 1'b0;
        i_re  = '0;
        i_im  = '0;
        i_rdy = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_vld", 64'(o_vld), 64'd0);
        chk("rst_norm", 64'(o_norm), 64'd0);
        chk("rst_energy", 64'(o_energy), 64'd0);
        chk("rst_rdy", 64'(o_rdy), 64'd1);
        i_rst = 1'b0;

        // Back-to-back 4 x (3,4)
        ra = '{3, 3, 3, 3};
        ia = '{4, 4, 4, 4};
        send_vec(ra, ia, 1'b0, lc);
        get_result("b2b", lc, 1'b1, e);
        chk("b2b_energy_100", 64'(o_energy), 64'd100);
        chk("b2b_norm_10", 64'(o_norm), 64'd10);
        release_check("b2b");

        // Most negative components: energy 2^33
        ra = '{-32768, -32768, -32768, -32768};
        ia = '{-32768, -32768, -32768, -32768};
        send_vec(ra, ia, 1'b0, lc);
        get_result("maxneg", lc, 1'b1, e);
        chk("maxneg_energy_2p33", 64'(o_energy), 64'd8589934592);
`ifdef CPLX_VEC_NORM_ROUND_EN
        chk("maxneg_norm_const", 64'(o_norm), 64'd92682);
`else
        chk("maxneg_norm_const", 64'(o_norm), 64'd92681);
`endif
        release_check("maxneg");

        // Energy 3: rounding differs from floor
        ra = '{1, 1, 0, 0};
        ia = '{1, 0, 0, 0};
        send_vec(ra, ia, 1'b0, lc);
        get_result("e3", lc, 1'b0, e);
        release_check("e3");

        // Energy 2: rounding and floor agree
        ra = '{1, 0, 0, 0};
        ia = '{1, 0, 0, 0};
        send_vec(ra, ia, 1'b0, lc);
        get_result("e2", lc, 1'b0, e);
        chk("e2_norm_1", 64'(o_norm), 64'd1);
        release_check("e2");

        // Backpressure: hold i_rdy low for 10 cycles in DONE with i_vld high
        i_rdy = 1'b0;
        ra = '{100, -200, 300, -400};
        ia = '{-7, 8, -9, 10};
        send_vec(ra, ia, 1'b0, lc);
        get_result("bp", lc, 1'b1, e);
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            i_vld = 1'b1;
            i_re  = W'(123);
            i_im  = W'(-45);
            chk("bp_hold_vld", 64'(o_vld), 64'd1);
            chk("bp_hold_rdy", 64'(o_rdy), 64'd0);
            chk("bp_hold_norm", 64'(o_norm), 64'(e.norm));
            chk("bp_hold_energy", 64'(o_energy), 64'(e.energy));
        end
        @(negedge i_clk);
        i_vld = 1'b0;
        i_rdy = 1'b1;
        release_check("bp");
        ra = '{0, 0, 0, 0};
        ia = '{5, 5, 5, 5};
        send_vec(ra, ia, 1'b0, lc);
        get_result("after_bp", lc, 1'b1, e);
        chk("after_bp_norm_10", 64'(o_norm), 64'd10);
        release_check("after_bp");

        // Gapped input: same result, latency from the last accept
        ra = '{3, 3, 3, 3};
        ia = '{4, 4, 4, 4};
        send_vec(ra, ia, 1'b1, lc);
        get_result("gap", lc, 1'b1, e);
        release_check("gap");

        // A few random vectors
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < N; i++) begin
                ra[i] = int'($urandom_range(65535)) - 32768;
                ia[i] = int'($urandom_range(65535)) - 32768;
            end
            send_vec(ra, ia, 1'b0, lc);
            get_result("rand", lc, 1'b1, e);
            release_check("rand");
        end

        // Reset in the middle of SQRT discards the vector
        ra = '{1, 1, 1, 1};
        ia = '{1, 1, 1, 1};
        send_vec(ra, ia, 1'b0, lc);
        repeat (4) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("midrst_vld", 64'(o_vld), 64'd0);
        chk("midrst_norm", 64'(o_norm), 64'd0);
        chk("midrst_energy", 64'(o_energy), 64'd0);
        chk("midrst_rdy", 64'(o_rdy), 64'd1);
        sb.delete();
        @(negedge i_clk);
        i_rst    = 1'b0;
        spurious = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge i_clk);
            if (o_vld !== 1'b0) spurious++;
        end
        chk("midrst_no_spurious_vld", 64'(spurious), 64'd0);
        ra = '{6, 6, 6, 6};
        ia = '{8, 8, 8, 8};
        send_vec(ra, ia, 1'b0, lc);
        get_result("post_rst", lc, 1'b1, e);
        chk("post_rst_energy_400", 64'(o_energy), 64'd400);
        chk("post_rst_norm_20", 64'(o_norm), 64'd20);
        release_check("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cplx_vec_norm.md
# cplx_vec_norm

Parametrised streaming column-norm unit for the QR datapath. It accepts N complex samples of one matrix column, accumulates their energy Σ(re²+im²), and computes the integer square root with a bit-serial restoring iterator. It presents the norm and the raw energy to the downstream normalisation/divide stage over a valid/ready handshake. This is the generalised successor of the engine's fixed 4-element, 16-bit column-0 norm path: width and depth are configurable, input has flow control, and output has backpressure.

## Interface
- W, 16: signed width of each real/imag component.
- N, 4: samples per vector, ≥1.
- Derived, not overridable:
  - ACC_W = 2W + clog2(N) (with clog2(1)=0).
  - R = ceil(ACC_W/2), the root width; 17 for the defaults.
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_vld  in  1  input sample valid.
- i_re  in  W  signed real part.
- i_im  in  W  signed imaginary part.
- o_rdy  out  1  unit can accept a sample this cycle.
- o_vld  out  1  result valid; held until accepted.
- i_rdy  in  1  downstream accepts the result.
- o_norm  out  R  unsigned norm.
- o_energy  out  ACC_W  unsigned accumulated energy.

## Operation
- States and transitions:
  - IDLE → ACC on the first accepted sample.
  - ACC → SQRT on the accepted sample with index N-1.
  - SQRT → DONE after exactly R iterations.
  - DONE → IDLE when i_rdy=1.
  - For N=1, IDLE → SQRT directly.
- Accept: a sample is taken when i_vld & o_rdy at the rising edge. o_rdy = 1 in IDLE/ACC, 0 in SQRT/DONE. This is a combinational state decode.
- Sample counter: width clog2(N) (min 1). It is cleared on entry to IDLE and wraps to 0 after the last sample.
- Energy: acc += re² + im², computed with signed multiplies.
  - Each square is ≤ 2^(2W-2), so the sum never overflows ACC_W.
  - (-2^(W-1))² is exact and is not saturated.
  - acc is cleared when the first sample of a vector is accepted, so a new vector never inherits the old energy.
- Sqrt: restoring, MSB-first, one root bit per cycle.
  - Operand is acc zero-extended to 2R bits.
  - Holds a remainder of R+2 bits and a root of R bits.
  - Result = floor(√acc).
- DONE:
  - o_norm and o_energy stay stable while o_vld=1 and i_rdy=0.
  - i_vld is ignored (o_rdy=0).
- Reset, including mid-ACC or mid-SQRT: state IDLE, counter and acc cleared, partial vector discarded, no o_vld pulse.
- Outputs after reset: o_vld=0, o_norm=0, o_energy=0, o_rdy=1.

## Timing
- Throughput: one sample per cycle when i_vld stays high.
- Let c be the cycle in which the last sample is accepted:
  - SQRT occupies cycles c+1 … c+R.
  - o_vld=1 from cycle c+R+1.
  - Latency is R+1 cycles (18 for the defaults).
- o_norm and o_energy are registered and update only on the SQRT→DONE transition. They keep their values in IDLE/ACC until the next result.
- Handshake completes on an edge with o_vld & i_rdy. o_rdy=1 in the next cycle.
- Minimum vector period with i_rdy tied high: N + R + 1 cycles.
- i_rdy held high in advance: DONE lasts exactly 1 cycle.
- i_vld high during SQRT/DONE: no accept, no state change.

## Configuration
- CPLX_VEC_NORM_ROUND_EN defined:
  - o_norm is round-to-nearest of √acc. Add 1 when the final remainder (acc − root²) > root.
  - Saturate to 2^R − 1 if the increment would overflow.
  - Rounding is applied in the SQRT→DONE cycle, so latency is unchanged.
- Undefined: o_norm = floor(√acc) with no rounding logic. o_energy is identical in both builds.

## Test plan
- W=16, N=4: feed 4×(3,4) back-to-back → o_energy=100, o_norm=10, o_vld exactly 18 cycles after the 4th accept.
- All samples (−32768,−32768) → o_energy=8589934592 (2^33). o_norm=92681 without the macro, 92682 with CPLX_VEC_NORM_ROUND_EN.
- Samples (1,1),(1,0),(0,0),(0,0) → o_energy=3. o_norm=1 floor, 2 rounded. Samples (1,1),0,0,0 → o_energy=2, o_norm=1 in both builds.
- Backpressure: i_rdy=0 for 10 cycles in DONE → o_vld, o_norm and o_energy are stable and o_rdy=0. Raise i_rdy → o_vld drops and o_rdy=1 the next cycle. A following vector of 4×(0,5) → o_norm=10.
- Gapped input (i_vld toggling 1,0,1,0…) → same results as the back-to-back case. The counter advances only on accepts.
- Assert i_rst mid-SQRT, then feed 4×(6,8) → no spurious o_vld. Outputs read 0 during reset, then o_energy=400 and o_norm=20.
